// File: rtl/i2c_master_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_master_ctrl
//   Single-master I2C register-access engine. A rising edge on en (while idle)
//   writes the register pointer to a 7-bit slave, then writes or reads 0/1/2
//   data bytes. No arbitration, no clock stretching.
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset
//   en               start request (rising edge while idle)
//   mode[1:0]        data byte count: 0=pointer only, 1=one byte, 2/3=two bytes
//   slave_address    7-bit slave address
//   target_register  register pointer byte
//   rw               0=write data, 1=read data
//   din[15:0]        write data (1 byte: din[7:0]; 2 bytes: din[15:8] then din[7:0])
//   dout[15:0]       read data (1 byte: {8'h00,b}; 2 bytes: {first,second})
//   scl              I2C clock, push-pull, idles high
//   sda              I2C data, open-drain (0 or 'z'), also sampled
//   busy             high from start acceptance until STOP completes
//   ack_err          slave NACK aborted the last transaction
// ---------------------------------------------------------------------------
module i2c_master_ctrl #(
  parameter int QUARTER_DIV = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [6:0]  slave_address,
  input  logic [7:0]  target_register,
  input  logic        rw,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        scl,
  inout  wire         sda,
  output logic        busy,
  output logic        ack_err
);

  localparam int DIV_W = (QUARTER_DIV > 1) ? $clog2(QUARTER_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(QUARTER_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, REG, WDATA, RSTART, ADDR_R, RDATA, MACK, STOP
  } state_t;

  state_t            state_reg, state_next;
  logic [DIV_W-1:0]  div_reg, div_next;
  logic [2:0]        qtr_reg, qtr_next;     // quarter index within a bit/sequence
  logic [3:0]        bit_reg, bit_next;     // bit index within a byte (8 = ack slot)
  logic [7:0]        tx_reg, tx_next;       // outgoing byte, MSB in bit 7
  logic [15:0]       rx_reg, rx_next;       // incoming read bytes
  logic [1:0]        left_reg, left_next;   // data bytes still to transfer
  logic [1:0]        nbytes_reg, nbytes_next;
  logic [6:0]        addr_reg, addr_next;
  logic [7:0]        ptr_reg, ptr_next;
  logic              rw_reg, rw_next;
  logic [15:0]       din_reg, din_next;
  logic              nack_reg, nack_next;
  logic [15:0]       dout_reg, dout_next;
  logic              ack_err_reg, ack_err_next;
  logic              busy_reg;
  logic              scl_reg;
  logic              sda_pre_reg, sda_rel_reg; // 1 = release the line
  logic              en_d_reg;

  logic              scl_c, sda_c;
  logic [2:0]        last_q;
  logic [3:0]        last_bit;
  logic              tick, tx_state, sda_in;

  assign sda_in  = sda;
  assign tick    = (div_reg == DIV_LAST);
  assign tx_state = (state_reg == ADDR_W) || (state_reg == REG) ||
                    (state_reg == WDATA)  || (state_reg == ADDR_R);

  // Bus levels and sequence lengths for the current state/quarter.
  always_comb begin
    scl_c    = 1'b1;
    sda_c    = 1'b1;
    last_q   = 3'd3;
    last_bit = 4'd0;
    unique case (state_reg)
      START: begin
        sda_c = (qtr_reg < 3'd2);
      end
      RSTART: begin
        // release SDA with SCL low, raise SCL, then a normal START
        last_q = 3'd5;
        scl_c  = (qtr_reg >= 3'd2);
        sda_c  = (qtr_reg < 3'd4);
      end
      STOP: begin
        // final quarter releases SDA while SCL is high (the STOP edge)
        last_q = 3'd4;
        scl_c  = (qtr_reg >= 3'd2);
        sda_c  = (qtr_reg == 3'd4);
      end
      ADDR_W, REG, WDATA, ADDR_R: begin
        last_bit = 4'd8;
        scl_c    = qtr_reg[1];
        sda_c    = (bit_reg == 4'd8) | tx_reg[7];
      end
      RDATA: begin
        last_bit = 4'd7;
        scl_c    = qtr_reg[1];
      end
      MACK: begin
        scl_c = qtr_reg[1];
        sda_c = (left_reg == 2'd1);   // NACK after the last byte
      end
      default: begin
        scl_c = 1'b1;
        sda_c = 1'b1;
      end
    endcase
  end

  // Next-state and datapath.
  always_comb begin
    state_next   = state_reg;
    div_next     = div_reg;
    qtr_next     = qtr_reg;
    bit_next     = bit_reg;
    tx_next      = tx_reg;
    rx_next      = rx_reg;
    left_next    = left_reg;
    nbytes_next  = nbytes_reg;
    addr_next    = addr_reg;
    ptr_next     = ptr_reg;
    rw_next      = rw_reg;
    din_next     = din_reg;
    nack_next    = nack_reg;
    dout_next    = dout_reg;
    ack_err_next = ack_err_reg;

    if (state_reg == IDLE) begin
      div_next = '0;
      qtr_next = '0;
      bit_next = '0;
      if (en && !en_d_reg) begin
        state_next   = START;
        addr_next    = slave_address;
        ptr_next     = target_register;
        rw_next      = rw;
        din_next     = din;
        nbytes_next  = (mode == 2'd0) ? 2'd0 : ((mode == 2'd1) ? 2'd1 : 2'd2);
        ack_err_next = 1'b0;
      end
    end else begin
      div_next = tick ? '0 : div_reg + DIV_W'(1);
      if (tick) begin
        // sample point: end of q2 = start of q3
        if (qtr_reg == 3'd2) begin
          if (state_reg == RDATA)
            rx_next = {rx_reg[14:0], sda_in};
          else if (tx_state && bit_reg == 4'd8)
            nack_next = sda_in;
        end
        if (qtr_reg != last_q) begin
          qtr_next = qtr_reg + 3'd1;
        end else begin
          qtr_next = '0;
          if (bit_reg != last_bit) begin
            bit_next = bit_reg + 4'd1;
            tx_next  = {tx_reg[6:0], 1'b0};
          end else begin
            bit_next = '0;
            unique case (state_reg)
              START: begin
                state_next = ADDR_W;
                tx_next    = {addr_reg, 1'b0};
              end
              ADDR_W: begin
                if (nack_reg) begin
                  state_next   = STOP;
                  ack_err_next = 1'b1;
                end else begin
                  state_next = REG;
                  tx_next    = ptr_reg;
                end
              end
              REG: begin
                if (nack_reg) begin
                  state_next   = STOP;
                  ack_err_next = 1'b1;
                end else if (nbytes_reg == 2'd0) begin
                  state_next = STOP;
                end else if (rw_reg) begin
                  state_next = RSTART;
                end else begin
                  state_next = WDATA;
                  left_next  = nbytes_reg;
                  tx_next    = (nbytes_reg == 2'd2) ? din_reg[15:8] : din_reg[7:0];
                end
              end
              WDATA: begin
                if (nack_reg) begin
                  state_next   = STOP;
                  ack_err_next = 1'b1;
                end else if (left_reg == 2'd1) begin
                  state_next = STOP;
                end else begin
                  left_next = left_reg - 2'd1;
                  tx_next   = din_reg[7:0];
                end
              end
              RSTART: begin
                state_next = ADDR_R;
                tx_next    = {addr_reg, 1'b1};
              end
              ADDR_R: begin
                if (nack_reg) begin
                  state_next   = STOP;
                  ack_err_next = 1'b1;
                end else begin
                  state_next = RDATA;
                  left_next  = nbytes_reg;
                  rx_next    = '0;
                end
              end
              RDATA: state_next = MACK;
              MACK: begin
                if (left_reg == 2'd1) begin
                  state_next = STOP;
                  dout_next  = rx_reg;
                end else begin
                  state_next = RDATA;
                  left_next  = left_reg - 2'd1;
                end
              end
              STOP:    state_next = IDLE;
              default: state_next = IDLE;
            endcase
          end
        end
      end
    end
  end

  // SCL follows the state by one cycle and SDA by two, so SDA always moves
  // one clk after SCL has gone low (hold time on the data line).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      div_reg     <= '0;
      qtr_reg     <= '0;
      bit_reg     <= '0;
      tx_reg      <= '0;
      rx_reg      <= '0;
      left_reg    <= '0;
      nbytes_reg  <= '0;
      addr_reg    <= '0;
      ptr_reg     <= '0;
      rw_reg      <= 1'b0;
      din_reg     <= '0;
      nack_reg    <= 1'b0;
      dout_reg    <= '0;
      ack_err_reg <= 1'b0;
      busy_reg    <= 1'b0;
      scl_reg     <= 1'b1;
      sda_pre_reg <= 1'b1;
      sda_rel_reg <= 1'b1;
      en_d_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      div_reg     <= div_next;
      qtr_reg     <= qtr_next;
      bit_reg     <= bit_next;
      tx_reg      <= tx_next;
      rx_reg      <= rx_next;
      left_reg    <= left_next;
      nbytes_reg  <= nbytes_next;
      addr_reg    <= addr_next;
      ptr_reg     <= ptr_next;
      rw_reg      <= rw_next;
      din_reg     <= din_next;
      nack_reg    <= nack_next;
      dout_reg    <= dout_next;
      ack_err_reg <= ack_err_next;
      busy_reg    <= (state_next != IDLE);
      scl_reg     <= scl_c;
      sda_pre_reg <= sda_c;
      sda_rel_reg <= sda_pre_reg;
      en_d_reg    <= en;
    end
  end

  assign sda     = sda_rel_reg ? 1'bz : 1'b0;
  assign scl     = scl_reg;
  assign busy    = busy_reg;
  assign dout    = dout_reg;
  assign ack_err = ack_err_reg;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_ctrl
//   Self-checking bench: a bus-level I2C slave/monitor decodes START, STOP,
//   bytes and master ACKs into a token stream, which is compared against the
//   token stream predicted from the transaction rules. Random transactions
//   follow a set of directed ones.
// ---------------------------------------------------------------------------
module tb_i2c_master_ctrl;
  localparam int QD       = 4;
  localparam int BIT_CLKS = 4 * QD;
  localparam int TOK_S    = 'h100;
  localparam int TOK_P    = 'h200;
  localparam int TOK_MACK = 'h300;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [6:0]  slave_address;
  logic [7:0]  target_register;
  logic        rw;
  logic [15:0] din;
  logic [15:0] dout;
  logic        scl;
  wire         sda;
  logic        busy;
  logic        ack_err;

  logic slv_low = 1'b0;
  assign sda = slv_low ? 1'b0 : 1'bz;
  pullup (sda);

  logic sda_bit;
  assign sda_bit = (sda === 1'b0) ? 1'b0 : 1'b1;

  always #5 clk = ~clk;

  i2c_master_ctrl #(.QUARTER_DIV(QD)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .slave_address(slave_address),
    .target_register(target_register), .rw(rw), .din(din), .dout(dout),
    .scl(scl), .sda(sda), .busy(busy), .ack_err(ack_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- bus monitor + slave ----------------
  int         bus_q[$];
  int         bit_i = -1, byte_no = 0, mst_idx = 0, rd_idx = 0;
  int         nack_at = -1;
  int         bad_period = 0;
  int         cyc = 0, last_rise = 0;
  logic [7:0] cur_byte = 8'h00, tx_byte = 8'h00;
  logic [7:0] rd_data [2];
  bit         rd_mode = 1'b0, slave_tx = 1'b0, in_txn = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;

  always @(negedge clk) begin
    logic s;
    s = sda_bit;
    cyc++;
    if (rst) begin
      slv_low  = 1'b0;
      bit_i    = -1;
      in_txn   = 1'b0;
      rd_mode  = 1'b0;
      slave_tx = 1'b0;
      prev_scl = 1'b1;
      prev_sda = 1'b1;
    end else begin
      if (!busy) in_txn = 1'b0;
      if (prev_scl && scl && prev_sda && !s) begin
        if (!in_txn) begin
          in_txn  = 1'b1;
          mst_idx = 0;
          rd_idx  = 0;
        end
        bus_q.push_back(TOK_S);
        bit_i = -1; byte_no = 0; rd_mode = 1'b0; slave_tx = 1'b0; slv_low = 1'b0;
      end else if (prev_scl && scl && !prev_sda && s) begin
        bus_q.push_back(TOK_P);
        bit_i = -1; slv_low = 1'b0;
      end else if (!prev_scl && scl) begin
        if (bit_i >= 1 && (cyc - last_rise) != BIT_CLKS) bad_period++;
        last_rise = cyc;
        if (bit_i >= 0 && bit_i < 8) begin
          cur_byte = {cur_byte[6:0], s};
        end else if (bit_i == 8) begin
          if (slave_tx) begin
            bus_q.push_back(TOK_MACK | int'(s));
            if (s) rd_mode = 1'b0;
          end else begin
            bus_q.push_back(int'(cur_byte));
            if (byte_no == 0) rd_mode = cur_byte[0] && !s;
          end
        end
      end else if (prev_scl && !scl) begin
        if (bit_i == 8) begin
          if (!slave_tx) mst_idx++;
          bit_i    = 0;
          byte_no++;
          slave_tx = rd_mode;
          if (slave_tx) begin
            tx_byte = (rd_idx < 2) ? rd_data[rd_idx] : 8'hFF;
            rd_idx++;
          end
        end else begin
          bit_i++;
        end
        if (slave_tx && bit_i >= 0 && bit_i < 8) slv_low = ~tx_byte[7 - bit_i];
        else if (!slave_tx && bit_i == 8)        slv_low = (mst_idx != nack_at);
        else                                     slv_low = 1'b0;
      end
      prev_scl = scl;
      prev_sda = s;
    end
  end

  // ---------------- reference model ----------------
  int          exp_q[$];
  logic        exp_err;
  logic [15:0] model_dout = 16'h0000;

  task automatic ref_model(input logic [6:0] a, input logic [7:0] r, input logic w,
                           input logic [1:0] m, input logic [15:0] d, input int nk,
                           input logic [7:0] r0, input logic [7:0] r1);
    int n;
    n = (m == 2'd0) ? 0 : ((m == 2'd1) ? 1 : 2);
    exp_q.delete();
    exp_err = 1'b0;
    exp_q.push_back(TOK_S);
    exp_q.push_back(int'({a, 1'b0}));
    if (nk == 0) begin exp_q.push_back(TOK_P); exp_err = 1'b1; return; end
    exp_q.push_back(int'(r));
    if (nk == 1) begin exp_q.push_back(TOK_P); exp_err = 1'b1; return; end
    if (n == 0) begin exp_q.push_back(TOK_P); return; end
    if (!w) begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(int'((n == 2 && i == 0) ? d[15:8] : d[7:0]));
        if (nk == 2 + i) begin exp_q.push_back(TOK_P); exp_err = 1'b1; return; end
      end
    end else begin
      exp_q.push_back(TOK_S);
      exp_q.push_back(int'({a, 1'b1}));
      if (nk == 2) begin exp_q.push_back(TOK_P); exp_err = 1'b1; return; end
      for (int i = 0; i < n; i++) exp_q.push_back(TOK_MACK | ((i == n - 1) ? 1 : 0));
      model_dout = (n == 1) ? {8'h00, r0} : {r0, r1};
    end
    exp_q.push_back(TOK_P);
  endtask

  int txn_no = 0;

  task automatic run_txn(input logic [6:0] a, input logic [7:0] r, input logic w,
                         input logic [1:0] m, input logic [15:0] d, input int nk,
                         input logic [7:0] r0, input logic [7:0] r1,
                         input bit hold, input bit poke);
    int t, nq;
    ref_model(a, r, w, m, d, nk, r0, r1);
    bus_q.delete();
    bad_period = 0;
    nack_at    = nk;
    rd_data[0] = r0;
    rd_data[1] = r1;
    @(negedge clk);
    slave_address = a; target_register = r; rw = w; mode = m; din = d; en = 1'b1;
    @(negedge clk);
    chk("busy_next_cycle", 32'(busy), 32'd1);
    if (!hold) en = 1'b0;
    // changes after acceptance must not matter
    slave_address = 7'($urandom); target_register = 8'($urandom);
    rw = 1'($urandom); mode = 2'($urandom); din = 16'($urandom);
    if (poke && !hold) begin
      repeat (60) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
    end
    t = 0;
    while (busy && t < 5000) begin @(negedge clk); t++; end
    chk("busy_fall", 32'(busy), 32'd0);
    nq = bus_q.size();
    chk("token_count", 32'(nq), 32'(exp_q.size()));
    for (int i = 0; i < nq && i < exp_q.size(); i++)
      chk($sformatf("token[%0d]", i), 32'(bus_q[i]), 32'(exp_q[i]));
    chk("ack_err", 32'(ack_err), 32'(exp_err));
    chk("dout", 32'(dout), 32'(model_dout));
    chk("scl_period", 32'(bad_period), 32'd0);
    chk("idle_scl", 32'(scl), 32'd1);
    chk("idle_sda", 32'(sda_bit), 32'd1);
    if (hold) begin
      repeat (100) @(negedge clk);
      chk("no_retrigger_busy", 32'(busy), 32'd0);
      chk("no_retrigger_bus", 32'(bus_q.size()), 32'(nq));
      en = 1'b0;
    end
    txn_no++;
    $display("txn %0d addr=%h reg=%h rw=%0d mode=%0d din=%h nack_at=%0d tokens=%0d ack_err=%0d dout=%h",
             txn_no, a, r, w, m, d, nk, nq, ack_err, dout);
  endtask

  initial begin
    logic [6:0]  ra;
    logic [7:0]  rr;
    logic        rwv;
    logic [1:0]  rm;
    logic [15:0] rd;
    int          nk, mb;
    rst = 1'b1; en = 1'b0; mode = 2'd0; slave_address = 7'h0; target_register = 8'h0;
    rw = 1'b0; din = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_scl", 32'(scl), 32'd1);
    chk("reset_sda", 32'(sda_bit), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_ack_err", 32'(ack_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // directed
    run_txn(7'h49, 8'h96, 1'b0, 2'd1, 16'hAACC, -1, 8'h00, 8'h00, 1'b0, 1'b0);
    run_txn(7'h49, 8'h96, 1'b0, 2'd2, 16'hAACC, -1, 8'h00, 8'h00, 1'b0, 1'b0);
    run_txn(7'h49, 8'h96, 1'b0, 2'd0, 16'hAACC, -1, 8'h00, 8'h00, 1'b0, 1'b0);
    run_txn(7'h49, 8'h96, 1'b1, 2'd2, 16'h0000, -1, 8'h12, 8'h34, 1'b0, 1'b0);
    run_txn(7'h49, 8'h96, 1'b1, 2'd1, 16'h0000, -1, 8'h5A, 8'h00, 1'b0, 1'b0);
    run_txn(7'h49, 8'h96, 1'b1, 2'd1, 16'h0000, 0,  8'hEE, 8'h00, 1'b0, 1'b0);
    run_txn(7'h49, 8'h96, 1'b1, 2'd0, 16'h0000, -1, 8'h00, 8'h00, 1'b0, 1'b0);
    run_txn(7'h22, 8'h10, 1'b1, 2'd3, 16'h0000, 2,  8'h77, 8'h88, 1'b0, 1'b0);
    run_txn(7'h31, 8'h05, 1'b0, 2'd2, 16'hBEEF, 3,  8'h00, 8'h00, 1'b0, 1'b0);
    run_txn(7'h7F, 8'hFF, 1'b0, 2'd1, 16'h00A5, -1, 8'h00, 8'h00, 1'b1, 1'b0);
    run_txn(7'h00, 8'h00, 1'b1, 2'd2, 16'h0000, -1, 8'hC3, 8'h3C, 1'b0, 1'b1);

    // reset mid-transfer
    bus_q.delete();
    nack_at = -1;
    @(negedge clk);
    slave_address = 7'h55; target_register = 8'hA0; rw = 1'b0; mode = 2'd2; din = 16'h1234;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (200) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_scl", 32'(scl), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_sda", 32'(sda_bit), 32'd1);
    chk("rst_mid_dout", 32'(dout), 32'd0);
    chk("rst_mid_ack_err", 32'(ack_err), 32'd0);
    model_dout = 16'h0000;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    run_txn(7'h55, 8'hA0, 1'b0, 2'd2, 16'h1234, -1, 8'h00, 8'h00, 1'b0, 1'b0);

    // random
    for (int k = 0; k < 24; k++) begin
      ra  = 7'($urandom);
      rr  = 8'($urandom);
      rwv = 1'($urandom);
      rm  = 2'($urandom_range(0, 3));
      rd  = 16'($urandom);
      if (rm == 2'd0)  mb = 2;
      else if (rwv)    mb = 3;
      else             mb = (rm == 2'd1) ? 3 : 4;
      nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, mb - 1)) : -1;
      run_txn(ra, rr, rwv, rm, rd, nk, 8'($urandom), 8'($urandom), 1'b0, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
